conv33_window_sched: RTL and testbench

Sequencer for the 3x3 convolution window loader. It walks a stride-1, no-padding 3x3 window across an IMG_H x IMG_W feature map in raster order. For each position it issues a one-cycle window-start to the input controller, then waits for that controller's done pulse before advancing. It sits between the layer-level control FSM (start/done) and the conv33 input-control/datapath.

---
 rtl/conv33_window_sched.sv | 92 +++++++++
 tb/tb_conv33_window_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv33_window_sched.sv
// 3x3 stride-1 window sequencer: walks window top-left positions in raster
// order, one outstanding window at a time, with start/done handshaking.
module conv33_window_sched #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   input  logic              dn_ready,
   output logic              win_start,
   input  logic              win_done,
   output logic [ADDR_W-1:0] win_row,
   output logic [ADDR_W-1:0] win_col,
   output logic [ADDR_W-1:0] win_base,
   output logic [CNT_W-1:0]  win_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 3);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 3);

   state_t state;
   state_t state_nxt;
   logic   is_last;
   logic   load;
   logic   advance;

   assign is_last = (win_row == ROW_LAST) && (win_col == COL_LAST);
   assign load    = (state == IDLE) && start && !abort;
   assign advance = (state == WAIT) && win_done && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: if (dn_ready) state_nxt = WAIT;
            WAIT:  if (win_done) state_nxt = is_last ? FIN : ISSUE;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == FIN);
      win_start = (state == ISSUE) && dn_ready;
   end

   // Row wrap adds 3: (r, W-3) -> (r+1, 0) is exactly three pixels on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_row   <= '0;
         win_col   <= '0;
         win_base  <= '0;
         win_count <= '0;
      end else if (load) begin
         win_row   <= '0;
         win_col   <= '0;
         win_base  <= '0;
         win_count <= '0;
      end else if (advance) begin
         win_count <= win_count + CNT_W'(1);
         if (!is_last) begin
            if (win_col != COL_LAST) begin
               win_col  <= win_col + ADDR_W'(1);
               win_base <= win_base + ADDR_W'(1);
            end else begin
               win_col  <= '0;
               win_row  <= win_row + ADDR_W'(1);
               win_base <= win_base + ADDR_W'(3);
            end
         end
      end
   end

endmodule

// File: tb/tb_conv33_window_sched.sv
// Bench for conv33_window_sched: 5x5 map runs with stalls, spurious inputs,
// abort and async reset, plus a 3x3 minimum-map instance.
module tb_conv33_window_sched;

   logic       clk;
   logic       rst;
   logic       start, abort, dn_ready, win_done;
   logic       busy, done, win_start;
   logic [9:0] win_row, win_col, win_base, win_count;

   logic       s3_start, s3_ready, s3_wdone;
   logic       s3_busy, s3_done, s3_ws;
   logic [9:0] s3_row, s3_col, s3_base, s3_count;

   typedef struct {
      int row;
      int col;
      int base;
      int cnt;
   } exp_t;

   exp_t tbl[9];
   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   nstart = 0;
   int   ndone = 0;

   conv33_window_sched #(.IMG_W(5), .IMG_H(5), .ADDR_W(10), .CNT_W(10)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .busy(busy), .done(done), .dn_ready(dn_ready),
      .win_start(win_start), .win_done(win_done),
      .win_row(win_row), .win_col(win_col), .win_base(win_base),
      .win_count(win_count)
   );

   conv33_window_sched #(.IMG_W(3), .IMG_H(3), .ADDR_W(10), .CNT_W(10)) dut3 (
      .clk(clk), .rst(rst), .start(s3_start), .abort(1'b0),
      .busy(s3_busy), .done(s3_done), .dn_ready(s3_ready),
      .win_start(s3_ws), .win_done(s3_wdone),
      .win_row(s3_row), .win_col(s3_col), .win_base(s3_base),
      .win_count(s3_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // One cycle: sample/score at negedge, then move to just after posedge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (win_start) begin
         nstart++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL win_start_unexpected: got 1 want 0 base=%0d", win_base);
         end else begin
            e = q.pop_front();
            chk("sb_row", int'(win_row), e.row);
            chk("sb_col", int'(win_col), e.col);
            chk("sb_base", int'(win_base), e.base);
            chk("sb_count", int'(win_count), e.cnt);
         end
      end
      if (done) ndone++;
      @(posedge clk);
      #1;
   endtask

   task automatic serve(input int k, input bit spur);
      exp_t e;
      int   n0;
      e = tbl[k];
      e.cnt = k;
      q.push_back(e);
      n0 = nstart;
      if (spur) begin
         start = 1'b1;
         win_done = 1'b1;
      end
      step();
      chk("ws_fire", nstart, n0 + 1);
      start = 1'b0;
      win_done = 1'b0;
      step();
      win_done = 1'b1;
      step();
      win_done = 1'b0;
   endtask

   task automatic run_layer(input bit stall, input int spur_k);
      int d0;
      d0 = ndone;
      start = 1'b1;
      step();
      start = 1'b0;
      if (stall) begin
         dn_ready = 1'b0;
         repeat (4) begin
            step();
            chk("stall_ws", win_start, 0);
            chk("stall_busy", busy, 1);
            chk("stall_base", int'(win_base), 0);
         end
         dn_ready = 1'b1;
      end
      for (int k = 0; k < 9; k++) serve(k, k == spur_k);
      chk("fin_done", done, 1);
      chk("fin_busy", busy, 1);
      chk("fin_count", int'(win_count), 9);
      chk("fin_base", int'(win_base), 12);
      chk("fin_row", int'(win_row), 2);
      chk("fin_col", int'(win_col), 2);
      step();
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("ndone", ndone, d0 + 1);
      chk("q_empty", q.size(), 0);
   endtask

   initial begin
      tbl[0] = '{0, 0, 0, 0};
      tbl[1] = '{0, 1, 1, 0};
      tbl[2] = '{0, 2, 2, 0};
      tbl[3] = '{1, 0, 5, 0};
      tbl[4] = '{1, 1, 6, 0};
      tbl[5] = '{1, 2, 7, 0};
      tbl[6] = '{2, 0, 10, 0};
      tbl[7] = '{2, 1, 11, 0};
      tbl[8] = '{2, 2, 12, 0};

      rst = 1'b1;
      start = 1'b0; abort = 1'b0; dn_ready = 1'b1; win_done = 1'b0;
      s3_start = 1'b0; s3_ready = 1'b1; s3_wdone = 1'b0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ws", win_start, 0);
      chk("rst_base", int'(win_base), 0);
      chk("rst_count", int'(win_count), 0);
      rst = 1'b0;
      step();

      // Plain 5x5 run.
      run_layer(1'b0, -1);

      // Stall in ISSUE, then mid-layer start and spurious win_done.
      run_layer(1'b1, 4);

      // Abort in WAIT of the fourth window, with win_done the same cycle.
      begin
         exp_t e;
         int   d0;
         d0 = ndone;
         start = 1'b1;
         step();
         start = 1'b0;
         for (int k = 0; k < 3; k++) serve(k, 1'b0);
         e = tbl[3];
         e.cnt = 3;
         q.push_back(e);
         step();
         step();
         win_done = 1'b1;
         abort = 1'b1;
         step();
         win_done = 1'b0;
         abort = 1'b0;
         chk("abort_busy", busy, 0);
         chk("abort_done", done, 0);
         chk("abort_count", int'(win_count), 3);
         chk("abort_base", int'(win_base), 5);
         step();
         chk("abort_ndone", ndone, d0);
         chk("abort_busy2", busy, 0);
      end
      run_layer(1'b0, -1);

      // Async reset in WAIT.
      begin
         exp_t e;
         start = 1'b1;
         step();
         start = 1'b0;
         for (int k = 0; k < 2; k++) serve(k, 1'b0);
         e = tbl[2];
         e.cnt = 2;
         q.push_back(e);
         step();
         step();
         #2;
         rst = 1'b1;
         #1;
         chk("arst_busy", busy, 0);
         chk("arst_done", done, 0);
         chk("arst_ws", win_start, 0);
         chk("arst_row", int'(win_row), 0);
         chk("arst_col", int'(win_col), 0);
         chk("arst_base", int'(win_base), 0);
         chk("arst_count", int'(win_count), 0);
         step();
         rst = 1'b0;
         step();
         chk("arst_idle", busy, 0);
      end
      run_layer(1'b0, -1);

      // Minimum 3x3 map: one window.
      s3_start = 1'b1;
      step();
      s3_start = 1'b0;
      chk("m3_ws", s3_ws, 1);
      chk("m3_base", int'(s3_base), 0);
      step();
      chk("m3_wait_ws", s3_ws, 0);
      s3_wdone = 1'b1;
      step();
      s3_wdone = 1'b0;
      chk("m3_done", s3_done, 1);
      chk("m3_count", int'(s3_count), 1);
      chk("m3_busy_fin", s3_busy, 1);
      step();
      chk("m3_done_off", s3_done, 0);
      chk("m3_busy_off", s3_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
